// File: rtl/dmem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_read_arbiter
// Purpose  : Round-robin arbiter multiplexing NUM_REQ read clients onto one
//            dmem read port (registered 1-cycle read). At most one read is
//            issued per cycle; the grant is tagged with the client index and
//            the returned word is routed back with a one-hot valid.
// Ports    : i_CLK        clock (same clock as the dmem read port)
//            i_RSTn       synchronous active-low reset
//            i_REQ        per-client read request, held until granted
//            i_ADDR       client k address at [k*ADDR_WIDTH +: ADDR_WIDTH]
//            i_HOLD       blocks new grants this cycle
//            o_GNT        one-hot grant, combinational
//            o_MEM_EN     dmem read enable
//            o_MEM_ADDR   dmem read address
//            i_MEM_RDATA  dmem registered read data
//            o_RVALID     one-hot response valid (from registered tag)
//            o_RDATA      response data, shared by all clients
//            Optional (macro DMEM_ARB_STATS_EN):
//            i_CNT_CLR    clears all grant counters
//            o_GNT_CNT    saturating 16-bit grant counter per client
// Revision : 1.0 - initial release
// ============================================================================
module dmem_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          i_CLK,
  input  logic                          i_RSTn,
  input  logic [NUM_REQ-1:0]            i_REQ,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_ADDR,
  input  logic                          i_HOLD,
  output logic [NUM_REQ-1:0]            o_GNT,
  output logic                          o_MEM_EN,
  output logic [ADDR_WIDTH-1:0]         o_MEM_ADDR,
  input  logic [DATA_WIDTH-1:0]         i_MEM_RDATA,
  output logic [NUM_REQ-1:0]            o_RVALID,
  output logic [DATA_WIDTH-1:0]         o_RDATA
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic                          i_CNT_CLR,
  output logic [NUM_REQ*16-1:0]         o_GNT_CNT
`endif
);

  localparam int          PW     = $clog2(NUM_REQ);
  localparam logic [PW:0] NREQ_W = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

  logic [PW-1:0]         ptr;
  logic                  tag_valid;
  logic [PW-1:0]         tag_id;
  logic                  gnt_found;
  logic [PW-1:0]         gnt_idx;
  logic [PW:0]           scan_idx;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_addr
    assign addr_arr[k] = i_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Scan offsets from highest to lowest so the last hit written is the one
  // closest to the pointer, i.e. the round-robin winner.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    if (i_RSTn && !i_HOLD) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        scan_idx = {1'b0, ptr} + (PW+1)'(i);
        if (scan_idx >= NREQ_W) scan_idx = scan_idx - NREQ_W;
        if (i_REQ[scan_idx[PW-1:0]]) begin
          gnt_found = 1'b1;
          gnt_idx   = scan_idx[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    o_GNT      = '0;
    o_MEM_EN   = gnt_found;
    o_MEM_ADDR = '0;
    if (gnt_found) begin
      o_GNT[gnt_idx] = 1'b1;
      o_MEM_ADDR     = addr_arr[gnt_idx];
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      ptr       <= '0;
      tag_valid <= 1'b0;
      tag_id    <= '0;
    end else begin
      tag_valid <= gnt_found;
      if (gnt_found) begin
        tag_id <= gnt_idx;
        ptr    <= (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
      end
    end
  end

  // Gating with i_RSTn drops the response of a grant issued just before
  // reset is asserted.
  always_comb begin
    o_RVALID = '0;
    if (tag_valid && i_RSTn) o_RVALID[tag_id] = 1'b1;
  end

  assign o_RDATA = i_MEM_RDATA;

`ifdef DMEM_ARB_STATS_EN
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
    logic [15:0] cnt;
    always_ff @(posedge i_CLK) begin
      if (!i_RSTn || i_CNT_CLR) begin
        cnt <= '0;
      end else if (o_GNT[k] && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
    end
    assign o_GNT_CNT[k*16 +: 16] = cnt;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_read_arbiter
// Purpose  : Self-checking bench for dmem_read_arbiter (NUM_REQ=4). Drives
//            directed scenarios followed by random traffic and compares the
//            DUT against a round-robin reference model and a dmem model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_read_arbiter;

  localparam int N  = 4;
  localparam int AW = 15;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    req = '0;
  logic [AW-1:0]   addr [N];
  logic [N*AW-1:0] addr_bus;
  logic            hold = 1'b0;
  logic [N-1:0]    gnt;
  logic            mem_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rdata;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
`ifdef DMEM_ARB_STATS_EN
  logic            cnt_clr = 1'b0;
  logic [N*16-1:0] gnt_cnt;
`endif

  int ntests = 0;
  int nfail  = 0;

  // reference model state
  int            m_ptr   = 0;
  bit            m_pv    = 1'b0;
  int            m_pid   = 0;
  logic [AW-1:0] m_paddr = '0;
  logic [N-1:0]  last_gnt;
  logic [DW-1:0] last_rdata;
  logic [N-1:0]  last_rvalid;

  always #5 clk = ~clk;

  assign addr_bus = {addr[3], addr[2], addr[1], addr[0]};

  dmem_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_CLK      (clk),
    .i_RSTn     (rstn),
    .i_REQ      (req),
    .i_ADDR     (addr_bus),
    .i_HOLD     (hold),
    .o_GNT      (gnt),
    .o_MEM_EN   (mem_en),
    .o_MEM_ADDR (mem_addr),
    .i_MEM_RDATA(mem_rdata),
    .o_RVALID   (rvalid),
    .o_RDATA    (rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .i_CNT_CLR  (cnt_clr),
    .o_GNT_CNT  (gnt_cnt)
`endif
  );

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    if (a == 15'h0010) return 32'hDEADBEEF;
    return ({17'd0, a} * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
  endfunction

  // dmem with registered read
  always @(posedge clk) if (mem_en) mem_rdata <= memval(mem_addr);

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check at negedge, advance the model, return #1
  // after the next posedge.
  task automatic step(input logic [N-1:0] r, input logic h, input logic rs);
    int            k;
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    req  = r;
    hold = h;
    rstn = rs;
    @(negedge clk);
    k  = (rs && !h) ? pick(r, m_ptr) : -1;
    eg = (k >= 0) ? N'(1 << k) : '0;
    ea = (k >= 0) ? addr[k] : '0;
    chk("gnt", 64'(gnt), 64'(eg));
    chk("mem_en", 64'(mem_en), 64'(k >= 0));
    chk("mem_addr", 64'(mem_addr), 64'(ea));
    chk("rvalid", 64'(rvalid), (m_pv && rs) ? 64'(1 << m_pid) : 64'd0);
    if (m_pv && rs) chk("rdata", 64'(rdata), 64'(memval(m_paddr)));
    last_gnt    = gnt;
    last_rdata  = rdata;
    last_rvalid = rvalid;
    if (!rs) begin
      m_ptr = 0;
      m_pv  = 1'b0;
    end else begin
      m_pv = (k >= 0);
      if (k >= 0) begin
        m_pid   = k;
        m_paddr = ea;
        m_ptr   = (k + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < N; k++) addr[k] = AW'(16'h0100 * (k + 1) + k);

    // reset state
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("reset_gnt", 64'(last_gnt), 64'd0);

    // 1: single request from client 0, address 0x10
    addr[0] = 15'h0010;
    step(4'b0001, 1'b0, 1'b1);
    chk("t1_gnt", 64'(last_gnt), 64'h1);
    step(4'b0000, 1'b0, 1'b1);
    chk("t1_rvalid", 64'(last_rvalid), 64'h1);
    chk("t1_rdata", 64'(last_rdata), 64'hDEADBEEF);

    // 2: all request for 8 cycles from pointer 0
    step(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      addr[i % N] = AW'(16'h0200 + i);
      step(4'b1111, 1'b0, 1'b1);
      chk("t2_order", 64'(last_gnt), 64'(1 << (i % N)));
    end
    step(4'b0000, 1'b0, 1'b1);

    // 3: pointer at 2, clients 0 and 1 requesting
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0011, 1'b0, 1'b1);
    chk("t3_first", 64'(last_gnt), 64'h1);
    step(4'b0010, 1'b0, 1'b1);
    chk("t3_second", 64'(last_gnt), 64'h2);
    step(4'b0000, 1'b0, 1'b1);

    // 4: hold for 3 cycles; prior grant's response still delivered
    step(4'b0001, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 1'b1, 1'b1);
      chk("t4_hold_gnt", 64'(last_gnt), 64'd0);
      if (i == 0) chk("t4_resp", 64'(last_rvalid), 64'h1);
    end
    step(4'b0100, 1'b0, 1'b1);
    chk("t4_after", 64'(last_gnt), 64'h4);

    // 5: reset right after a grant drops the response
    step(4'b0010, 1'b0, 1'b1);
    chk("t5_gnt", 64'(last_gnt), 64'h2);
    step(4'b0000, 1'b0, 1'b0);
    chk("t5_drop", 64'(last_rvalid), 64'd0);
    step(4'b1111, 1'b0, 1'b1);
    chk("t5_post", 64'(last_gnt), 64'h1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) addr[k] = AW'($urandom);
      step(N'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 29) != 0));
    end

`ifdef DMEM_ARB_STATS_EN
    // 6: saturation and clear of the grant counters
    step(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) step(4'b1000, 1'b0, 1'b1);
    chk("t6_sat", 64'(gnt_cnt[63:48]), 64'hFFFF);
    chk("t6_others", 64'(gnt_cnt[47:0]), 64'd0);
    cnt_clr = 1'b1;
    step(4'b1000, 1'b0, 1'b1);
    cnt_clr = 1'b0;
    chk("t6_clr", 64'(gnt_cnt[63:48]), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
